// File: rtl/miner_uart_pkg.sv
// Shared definitions for the golden-nonce UART transmitter.
package miner_uart_pkg;

  // Frame sequencer states: one start bit, eight data bits, one stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_BITS        = 8;    // data bits per UART character
  localparam int NONCE_BYTES      = 4;    // characters per 32-bit nonce
  localparam int DEFAULT_BAUD_DIV = 434;  // clock cycles per UART bit

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO for golden nonces with full/empty/level flags.
// A push while full is still accepted when a pop happens on the same edge.
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int LOG2  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             accepted,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    level
);

  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2-1:0]  wr_ptr;
  logic [LOG2-1:0]  rd_ptr;
  logic             pop_ok;

  assign full     = (level == (LOG2+1)'(DEPTH));
  assign empty    = (level == '0);
  assign pop_ok   = pop && !empty;
  assign accepted = push && (!full || pop_ok);
  assign dout     = mem[rd_ptr];  // first-word fall-through

  // Storage write; only the pointers carry the queue state.
  // NOTE: the array has no reset -- the level and pointers decide what is valid,
  // so clearing storage would only add a wide reset mux for nothing.
  always_ff @(posedge clk) begin
    if (accepted) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + LOG2'(1);
      if (pop_ok)   rd_ptr <= rd_ptr + LOG2'(1);
      case ({accepted, pop_ok})
        2'b10:   level <= level + (LOG2+1)'(1);
        2'b01:   level <= level - (LOG2+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Buffers golden nonces and sends each one as four 8N1 UART characters,
// least-significant byte first, so bursts of nonces are queued instead of lost.
module golden_nonce_uart_tx
  import miner_uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int FIFO_LOG2 = 3
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic                 nonce_valid,
  input  logic [31:0]          nonce,
  output logic                 TxD,
  output logic                 busy,
  output logic [FIFO_LOG2:0]   fifo_level,
  output logic [7:0]           drop_count
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_BITS - 1);
  localparam logic [1:0]  BYTE_LAST = 2'(NONCE_BYTES - 1);

  uart_state_e          state;
  logic [15:0]          baud_cnt;
  logic [2:0]           bit_idx;
  logic [1:0]           byte_idx;
  logic [31:0]          hold;      // word in flight, shifted right as bits leave

  logic [31:0]          fifo_dout;
  logic                 fifo_accepted;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic                 pop;
  logic                 drop;
  logic                 baud_end;
  logic                 frame_done;
  logic                 active_next;
  logic [FIFO_LOG2:0]   level_next;

  nonce_fifo #(
    .WIDTH (32),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk      (hash_clk),
    .reset    (reset),
    .push     (nonce_valid),
    .din      (nonce),
    .pop      (pop),
    .dout     (fifo_dout),
    .accepted (fifo_accepted),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign pop        = (state == IDLE) && !fifo_empty;
  assign drop       = nonce_valid && !fifo_accepted;
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign frame_done = (state == STOP) && baud_end && (byte_idx == BYTE_LAST);
  assign active_next = pop || ((state != IDLE) && !frame_done);

  // Queue occupancy after this edge, used to register busy without a cycle lag.
  // NOTE: the default assignment first keeps this block purely combinational;
  // leaving any path unassigned would infer a latch.
  always_comb begin
    level_next = fifo_level;
    if (fifo_accepted && !pop) begin
      level_next = fifo_level + (FIFO_LOG2+1)'(1);
    end else if (!fifo_accepted && pop) begin
      level_next = fifo_level - (FIFO_LOG2+1)'(1);
    end
  end

  // Frame sequencer: baud timing, bit/byte stepping and the registered line.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      hold     <= '0;
      TxD      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      busy <= active_next || (level_next != '0);

      if (state != IDLE) begin
        baud_cnt <= baud_end ? 16'd0 : baud_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            hold     <= fifo_dout;
            byte_idx <= '0;
            baud_cnt <= '0;
            TxD      <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            bit_idx <= '0;
            TxD     <= hold[0];
            hold    <= {1'b0, hold[31:1]};
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              TxD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TxD     <= hold[0];
              hold    <= {1'b0, hold[31:1]};
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (byte_idx == BYTE_LAST) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= START;
              TxD      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of nonces refused because the queue was full.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Self-checking bench: a queue-based line model checked every cycle, plus
// hand-computed expectations at key cycles of each directed scenario.
module tb_golden_nonce_uart_tx;

  localparam int BAUD_DIV  = 4;
  localparam int FIFO_LOG2 = 2;
  localparam int DEPTH     = 1 << FIFO_LOG2;

  logic                hash_clk = 1'b0;
  logic                reset = 1'b1;
  logic                nonce_valid = 1'b0;
  logic [31:0]         nonce = '0;
  logic                TxD;
  logic                busy;
  logic [FIFO_LOG2:0]  fifo_level;
  logic [7:0]          drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c0;

  golden_nonce_uart_tx #(
    .BAUD_DIV  (BAUD_DIV),
    .FIFO_LOG2 (FIFO_LOG2)
  ) dut (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .nonce_valid (nonce_valid),
    .nonce       (nonce),
    .TxD         (TxD),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  always @(posedge hash_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq holds queued nonces; line holds the future per-cycle line values of the
  // word in flight as {active, txd}, followed by one idle cycle.
  logic [31:0] mq[$];
  logic [1:0]  line[$];
  int          m_drop = 0;
  logic        exp_txd = 1'b1;
  logic        exp_busy = 1'b0;
  int          exp_level = 0;
  bit          model_valid = 1'b0;
  logic [1:0]  m_ent;
  logic [31:0] m_word;

  function automatic void add_frame(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < BAUD_DIV; k++) line.push_back(2'b10);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < BAUD_DIV; k++) line.push_back({1'b1, w[8*b+i]});
      for (int k = 0; k < BAUD_DIV; k++) line.push_back(2'b11);
    end
    line.push_back(2'b01);  // the idle cycle between words
  endfunction

  always @(posedge hash_clk) begin
    if (reset) begin
      mq.delete();
      line.delete();
      m_drop      = 0;
      exp_txd     = 1'b1;
      exp_busy    = 1'b0;
      exp_level   = 0;
      model_valid = 1'b1;
    end else begin
      if (line.size() == 0 && mq.size() > 0) begin
        m_word = mq.pop_front();
        add_frame(m_word);
      end
      m_ent = 2'b01;
      if (line.size() > 0) m_ent = line.pop_front();
      if (nonce_valid) begin
        if (mq.size() < DEPTH) mq.push_back(nonce);
        else if (m_drop < 255) m_drop++;
      end
      exp_txd   = m_ent[0];
      exp_busy  = m_ent[1] || (mq.size() != 0);
      exp_level = mq.size();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge hash_clk) begin
    if (model_valid) begin
      check("txd",        {31'b0, TxD},        {31'b0, exp_txd});
      check("busy",       {31'b0, busy},       {31'b0, exp_busy});
      check("fifo_level", 32'(fifo_level),     exp_level);
      check("drop_count", {24'b0, drop_count}, m_drop);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge hash_clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    nonce_valid = 1'b1;
    nonce       = w;
    @(posedge hash_clk);
    #1;
    nonce_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(posedge hash_clk);
      #1;
      n++;
    end
    check("drain_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge hash_clk);
    #1;
    check("rst_txd",   {31'b0, TxD},        32'd1);
    check("rst_busy",  {31'b0, busy},       32'd0);
    check("rst_level", 32'(fifo_level),     32'd0);
    check("rst_drop",  {24'b0, drop_count}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge hash_clk);
    #1;

    // Single word 0x12345678.
    c0 = cyc;
    push(32'h1234_5678);
    check("s1_busy_c1",  {31'b0, busy},   32'd1);
    check("s1_level_c1", 32'(fifo_level), 32'd1);
    check("s1_txd_c1",   {31'b0, TxD},    32'd1);
    goto(c0 + 2);   check("s1_start",    {31'b0, TxD}, 32'd0);
    goto(c0 + 6);   check("s1_b0_bit0",  {31'b0, TxD}, 32'd0);
    goto(c0 + 18);  check("s1_b0_bit3",  {31'b0, TxD}, 32'd1);
    goto(c0 + 38);  check("s1_b0_stop",  {31'b0, TxD}, 32'd1);
    goto(c0 + 42);  check("s1_b1_start", {31'b0, TxD}, 32'd0);
    goto(c0 + 46);  check("s1_b1_bit0",  {31'b0, TxD}, 32'd0);
    goto(c0 + 50);  check("s1_b1_bit1",  {31'b0, TxD}, 32'd1);
    goto(c0 + 126); check("s1_b3_bit0",  {31'b0, TxD}, 32'd0);
    goto(c0 + 142); check("s1_b3_bit4",  {31'b0, TxD}, 32'd1);
    goto(c0 + 161); check("s1_busy_161", {31'b0, busy}, 32'd1);
    goto(c0 + 162); check("s1_busy_162", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge hash_clk);
    #1;

    // Burst of three back-to-back nonces.
    c0 = cyc;
    push(32'hDEAD_BEEF);
    push(32'h0000_0001);
    push(32'hCAFE_F00D);
    check("s2_level_peak", 32'(fifo_level), 32'd2);
    check("s2_start0",     {31'b0, TxD},    32'd0);
    goto(c0 + 6);   check("s2_w0_bit0",  {31'b0, TxD}, 32'd1);
    goto(c0 + 162); check("s2_gap_idle", {31'b0, TxD}, 32'd1);
    goto(c0 + 163); check("s2_start1",   {31'b0, TxD}, 32'd0);
    goto(c0 + 167); check("s2_w1_bit0",  {31'b0, TxD}, 32'd1);
    goto(c0 + 324); check("s2_start2",   {31'b0, TxD}, 32'd0);
    goto(c0 + 328); check("s2_w2_bit0",  {31'b0, TxD}, 32'd1);
    wait_idle(1000);
    check("s2_drop", {24'b0, drop_count}, 32'd0);

    // Overflow with a word in flight, then a push on the pop edge while full.
    c0 = cyc;
    push(32'h0BAD_F00D);
    goto(c0 + 4);
    for (int i = 1; i <= 6; i++) push(32'h1111_1111 * i);
    check("s3_level_full", 32'(fifo_level),     32'd4);
    check("s3_drop",       {24'b0, drop_count}, 32'd2);
    goto(c0 + 162);
    check("s4_idle_gap",   {31'b0, TxD},        32'd1);
    push(32'hAAAA_5555);
    check("s4_level",      32'(fifo_level),     32'd4);
    check("s4_drop",       {24'b0, drop_count}, 32'd2);
    check("s4_start",      {31'b0, TxD},        32'd0);
    goto(c0 + 807); check("s4_last_start", {31'b0, TxD}, 32'd0);
    goto(c0 + 811); check("s4_last_bit0",  {31'b0, TxD}, 32'd1);
    goto(c0 + 815); check("s4_last_bit1",  {31'b0, TxD}, 32'd0);
    wait_idle(2000);
    check("s4_drop_end", {24'b0, drop_count}, 32'd2);

    // Reset during byte 2 of a word with two more queued.
    c0 = cyc;
    push(32'h0102_0304);
    push(32'h0506_0708);
    push(32'h090A_0B0C);
    goto(c0 + 90);
    check("s5_level_pre", 32'(fifo_level), 32'd2);
    reset = 1'b1;
    @(posedge hash_clk);
    #1;
    reset = 1'b0;
    check("s5_txd",   {31'b0, TxD},        32'd1);
    check("s5_level", 32'(fifo_level),     32'd0);
    check("s5_busy",  {31'b0, busy},       32'd0);
    check("s5_drop",  {24'b0, drop_count}, 32'd0);
    goto(c0 + 300);
    check("s5_txd_quiet",  {31'b0, TxD},  32'd1);
    check("s5_busy_quiet", {31'b0, busy}, 32'd0);

    // Saturation: far more than 255 refused pushes.
    push(32'h5A5A_0000);
    for (int i = 0; i < 330; i++) push(32'(i));
    check("s6_drop_sat", {24'b0, drop_count}, 32'd255);
    wait_idle(3000);
    check("s6_drop_hold", {24'b0, drop_count}, 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
